// File: rtl/value_dispatch_fsm.sv
// value_dispatch_fsm: routes a byte stream into a literal scanner and reports true/false/null literals
module value_dispatch_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_char,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] sv_char,
    output logic       sv_rst,
    output logic       sv_enb,
    input  logic       sv_complete,
    input  logic [1:0] sv_element,
    output logic [1:0] out_type,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    input  logic       err_clr
);
    localparam logic [1:0] noType = 2'd0;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, ERROR} stateT;

    stateT      state, nextState;
    logic [2:0] len, nextLen, lenInc;
    logic [1:0] nextType;
    logic       isSpace, isStart;

    assign sv_char   = in_char;
    assign out_valid = state == EMIT;
    assign err       = state == ERROR;
    assign isSpace   = in_char == 8'h20 || in_char == 8'h09 || in_char == 8'h0A || in_char == 8'h0D;
    assign isStart   = in_char == "t" || in_char == "f" || in_char == "n";
    assign lenInc    = (len == 3'd7) ? len : len + 3'd1;

    // state, literal length and recognised type registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len      <= 3'd0;
            out_type <= noType;
        end else begin
            state    <= nextState;
            len      <= nextLen;
            out_type <= nextType;
        end
    end

    // next-state and scanner strobes; strobes only fire on an accepted byte
    always_comb begin
        nextState = state;
        nextLen   = len;
        nextType  = out_type;
        in_ready  = 1'b0;
        sv_rst    = 1'b0;
        sv_enb    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && isStart) begin
                    sv_rst    = 1'b1;
                    nextLen   = 3'd1;
                    nextState = SCAN;
                end else if (in_valid && !isSpace) begin
                    nextState = ERROR;
                end
            end
            SCAN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sv_enb  = 1'b1;
                    nextLen = lenInc;
                    if (sv_element != noType) begin
                        nextType  = sv_element;
                        nextState = EMIT;
                    end else if (sv_complete || lenInc >= 3'd5) begin
                        nextState = ERROR;
                    end
                end
            end
            EMIT:    nextState = out_ready ? IDLE : EMIT;
            ERROR:   nextState = err_clr ? IDLE : ERROR;
            default: nextState = IDLE;
        endcase
    end
endmodule

// File: tb/tb_value_dispatch_fsm.sv
// tb_value_dispatch_fsm: directed and randomized checks of value_dispatch_fsm against a string-level model
module tb_value_dispatch_fsm;
    logic       clk, rst;
    logic [7:0] in_char;
    logic       in_valid, in_ready;
    logic [7:0] sv_char;
    logic       sv_rst, sv_enb, sv_complete;
    logic [1:0] sv_element, out_type;
    logic       out_valid, out_ready, err, err_clr;

    int    total = 0;
    int    bad = 0;
    string lit = "";
    string tgt = "true";
    int    pend = -1;
    bit    errFlag = 0;
    bit    quiet = 0;

    value_dispatch_fsm dut (
        .clk(clk), .rst(rst), .in_char(in_char), .in_valid(in_valid), .in_ready(in_ready),
        .sv_char(sv_char), .sv_rst(sv_rst), .sv_enb(sv_enb), .sv_complete(sv_complete),
        .sv_element(sv_element), .out_type(out_type), .out_valid(out_valid),
        .out_ready(out_ready), .err(err), .err_clr(err_clr)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [1:0] elemOf(input string s);
        return s == "true" ? 2'd1 : s == "false" ? 2'd2 : s == "null" ? 2'd3 : 2'd0;
    endfunction

    function automatic bit prefixOf(input string s, input string w);
        if (s.len() > w.len()) return 0;
        return w.substr(0, s.len() - 1) == s;
    endfunction

    function automatic bit anyPrefix(input string s);
        return prefixOf(s, "true") || prefixOf(s, "false") || prefixOf(s, "null");
    endfunction

    function automatic bit isWs(input logic [7:0] c);
        return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D;
    endfunction

    function automatic bit isStartCh(input logic [7:0] c);
        return c == "t" || c == "f" || c == "n";
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock cycle: drive at posedge+1, compare at negedge, advance the model at the edge
    task automatic step(input bit v, input logic [7:0] c, input bit ordy, input bit clr);
        string      cand;
        bit         scanning, expReady, xfer;
        logic [1:0] el;
        in_valid  = v;
        in_char   = c;
        out_ready = ordy;
        err_clr   = clr;
        cand      = $sformatf("%s%c", lit, c);
        scanning  = lit.len() > 0;
        el        = elemOf(cand);
        sv_element  = scanning ? el : 2'($urandom);
        sv_complete = scanning ? (!quiet && !anyPrefix(cand)) : 1'($urandom);
        expReady  = !errFlag && pend < 0;
        xfer      = v && expReady;
        @(negedge clk);
        check("in_ready", 8'(in_ready), 8'(expReady));
        check("sv_rst", 8'(sv_rst), 8'(xfer && !scanning && isStartCh(c)));
        check("sv_enb", 8'(sv_enb), 8'(xfer && scanning));
        check("sv_char", sv_char, c);
        check("out_valid", 8'(out_valid), 8'(pend >= 0));
        check("err", 8'(err), 8'(errFlag));
        if (pend >= 0) check("out_type", 8'(out_type), 8'(pend));
        if (errFlag) begin
            if (clr) errFlag = 0;
        end else if (pend >= 0) begin
            if (ordy) pend = -1;
        end else if (!scanning) begin
            if (xfer && isStartCh(c)) lit = cand;
            else if (xfer && !isWs(c)) errFlag = 1;
        end else if (xfer) begin
            if (el != 2'd0) begin
                pend = int'(el);
                lit = "";
            end else if (sv_complete || cand.len() >= 5) begin
                errFlag = 1;
                lit = "";
            end else begin
                lit = cand;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic resetPulse();
        in_valid = 0;
        err_clr  = 0;
        rst      = 1;
        #1;
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_err", 8'(err), 8'd0);
        check("rst_out_type", 8'(out_type), 8'd0);
        check("rst_sv_rst", 8'(sv_rst), 8'd0);
        check("rst_sv_enb", 8'(sv_enb), 8'd0);
        lit = "";
        pend = -1;
        errFlag = 0;
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input string s, input bit ordy);
        for (int i = 0; i < s.len(); i++) step(1, s[i], ordy, 0);
    endtask

    initial begin
        rst = 1; in_char = 0; in_valid = 0; out_ready = 0; err_clr = 0;
        sv_complete = 0; sv_element = 0;
        #2;
        resetPulse();
        feed(" true", 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        feed("null", 0);
        for (int i = 0; i < 3; i++) step(1, "t", 0, 0);
        step(0, 0, 1, 0);
        feed("falsx", 1);
        step(0, 0, 1, 0);
        step(1, "t", 1, 1);
        step(1, "t", 1, 0);
        step(0, 0, 1, 0);
        resetPulse();
        feed("7", 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        feed("tr", 1);
        resetPulse();
        feed("false", 1);
        step(1, "n", 1, 0);
        feed("ull", 1);
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, tgt[i], 1, 0);
            step(0, 0, 1, 0);
        end
        tgt = "null";
        for (int i = 0; i < 4; i++) begin
            step(1, tgt[i], 1, 0);
            step(0, 0, 1, 0);
        end
        step(0, 0, 1, 0);
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] c;
            int r;
            quiet = n >= 1500;
            r = $urandom_range(0, 9);
            if (lit.len() == 0) begin
                if (r < 6) begin
                    tgt = r < 2 ? "true" : r < 4 ? "false" : "null";
                    c = tgt[0];
                end else if (r < 8) begin
                    c = r == 6 ? 8'h20 : 8'h0A;
                end else begin
                    c = 8'($urandom);
                end
            end else begin
                c = r < 8 ? tgt[lit.len()] : 8'($urandom_range(33, 126));
            end
            if ($urandom_range(0, 199) == 0) resetPulse();
            else step($urandom_range(0, 3) != 0, c, 1'($urandom), $urandom_range(0, 2) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/value_dispatch_fsm.md
VALUE_DISPATCH_FSM -- requirements
Module: value_dispatch_fsm

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset; forces all state and outputs to reset values immediately.
REQ-003 in_char  input  8  UTF8_Char from upstream byte stream.
REQ-004 in_valid  input  1  in_char is valid this cycle.
REQ-005 in_ready  output  1  block accepts in_char this cycle; a byte transfers when in_valid && in_ready.
REQ-006 sv_char  output  8  byte driven to the simple-value scanner's curChar; equals in_char combinationally.
REQ-007 sv_rst  output  1  scanner restart pulse; scanner latches sv_char as literal byte 0.
REQ-008 sv_enb  output  1  scanner advance enable.
REQ-009 sv_complete  input  1  scanner scanComplete.
REQ-010 sv_element  input  ElementType  scanner scannedElement (noType, trueVal, falseVal, nullVal).
REQ-011 out_type  output  ElementType  recognised literal type.
REQ-012 out_valid  output  1  out_type is valid; held until out_ready.
REQ-013 out_ready  input  1  downstream accepts out_type.
REQ-014 err  output  1  sticky malformed-literal or unexpected-byte flag.
REQ-015 err_clr  input  1  synchronous clear of err; returns FSM to IDLE.

Function
REQ-016 States SHALL be IDLE, SCAN, EMIT, ERROR, held in a registered state variable.
REQ-017 IDLE: in_ready=1; whitespace bytes (0x20, 0x09, 0x0A, 0x0D) SHALL be consumed with no other effect.
REQ-018 IDLE, accepted 't', 'f' or 'n': SHALL assert sv_rst for that cycle, load len counter=1, go to SCAN.
REQ-019 IDLE, accepted any other non-whitespace byte: SHALL set err, go to ERROR.
REQ-020 SCAN: in_ready=1; each accepted byte SHALL assert sv_enb for that cycle and increment len (3-bit, saturating at 7).
REQ-021 SCAN, accepted byte with sv_element != noType in the same cycle: SHALL register out_type=sv_element, go to EMIT next cycle.
REQ-022 SCAN, accepted byte with sv_element == noType and (sv_complete==1 or len reaching 5): SHALL set err, go to ERROR.
REQ-023 SCAN with in_valid=0: SHALL hold state, len, and deassert sv_enb and sv_rst.
REQ-024 EMIT: out_valid=1, in_ready=0; out_type SHALL be stable until out_valid && out_ready, then go to IDLE the following cycle.
REQ-025 ERROR: in_ready=0, err=1, out_valid=0; leave only on err_clr (to IDLE, err=0) or rst.
REQ-026 err_clr in any state other than ERROR SHALL be ignored.
REQ-027 sv_rst and sv_enb SHALL never be asserted in the same cycle, and SHALL be 0 when no byte transfers.
REQ-028 Latency: last literal byte accepted in cycle N -> out_valid=1 in cycle N+1.
REQ-029 Back-to-back: a literal byte presented the cycle after EMIT->IDLE SHALL be accepted with no extra bubble.

Reset
REQ-030 On rst: state=IDLE, len=0, out_type=noType, out_valid=0, err=0, sv_rst=0, sv_enb=0; in_ready=1 once rst deasserts.
REQ-031 rst asserted mid-SCAN or mid-EMIT SHALL discard the partial literal and any pending out_type with no out_valid pulse.

Verification
REQ-032 Stream " true" with out_ready=1 -> space consumed, sv_rst on 't', sv_enb on "rue", out_valid 1 cycle after 'e', out_type=trueVal.
REQ-033 Stream "null" with out_ready=0 for 3 cycles -> out_valid held 3+ cycles, out_type=nullVal, in_ready=0 until handshake.
REQ-034 Stream "fals" then "x" -> err=1 after 'x', in_ready=0; err_clr -> err=0, state IDLE, in_ready=1.
REQ-035 Stream "7" in IDLE -> err=1 next cycle, no sv_rst, no out_valid.
REQ-036 "tr" then rst pulse, then "false" -> no output for "tr", out_type=falseVal after 'e'.
REQ-037 "true" then "null" with in_valid gaps of 1 cycle between bytes -> two out_valid pulses, trueVal then nullVal, len unaffected by gaps.
